// File: rtl/fetch_unit.sv
// Fetch front end: issues sequential instruction reads, tracks their PCs in order,
// and presents one registered {pc, instruction} pair per cycle to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic [31:0] FLUSH_PC,
  input  logic        STALL,
  output logic        INST_RDEN,
  output logic [31:0] INST_RIADDR,
  input  logic        INST_RREADY,
  input  logic        INST_RVALID,
  input  logic [31:0] INST_RDATA,
  output logic [31:0] INST_PC,
  output logic [31:0] INST_DATA
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam int DW = 16;
  localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);

  logic          started_q, started_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;
  logic [DW-1:0] disc_q, disc_d;
  logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [31:0]   inst_pc_q, inst_pc_d, inst_data_q, inst_data_d;

  logic [31:0]   pcq_mem_q  [DEPTH];
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_data_q [DEPTH];

  logic [OW-1:0] occ;
  logic          accept, deliver, drop, buf_empty, pop, push;

  always_comb begin
    occ         = OW'(out_q) + OW'(buf_cnt_q);
    INST_RDEN   = started_q && !FLUSH && (occ < DEPTH_OCC);
    INST_RIADDR = req_pc_q;
    accept      = INST_RDEN && INST_RREADY;
    drop        = INST_RVALID && (disc_q != '0);
    // A response with nothing outstanding and nothing to discard is ignored.
    deliver     = INST_RVALID && (disc_q == '0) && (out_q != '0) && !FLUSH;
    buf_empty   = (buf_cnt_q == '0);
    pop         = !STALL && !FLUSH && !buf_empty;
    push        = deliver && (STALL || !buf_empty);
  end

  always_comb begin
    started_d   = 1'b1;
    req_pc_d    = req_pc_q;
    out_d       = out_q;
    buf_cnt_d   = buf_cnt_q;
    disc_d      = disc_q;
    pcq_wr_d    = pcq_wr_q;
    pcq_rd_d    = pcq_rd_q;
    buf_wr_d    = buf_wr_q;
    buf_rd_d    = buf_rd_q;
    inst_pc_d   = inst_pc_q;
    inst_data_d = inst_data_q;
    if (FLUSH) begin
      req_pc_d    = FLUSH_PC & ~32'h3;
      out_d       = '0;
      buf_cnt_d   = '0;
      pcq_wr_d    = '0;
      pcq_rd_d    = '0;
      buf_wr_d    = '0;
      buf_rd_d    = '0;
      inst_pc_d   = '0;
      inst_data_d = '0;
      // Everything still in flight must be dropped when it eventually returns.
      disc_d = disc_q + DW'(out_q);
      if (INST_RVALID && (disc_d != '0)) disc_d = disc_d - DW'(1);
    end else begin
      if (accept) begin
        req_pc_d = req_pc_q + 32'd4;
        pcq_wr_d = pcq_wr_q + PW'(1);
      end
      if (deliver) pcq_rd_d = pcq_rd_q + PW'(1);
      if (drop)    disc_d   = disc_q - DW'(1);
      if (push)    buf_wr_d = buf_wr_q + PW'(1);
      if (pop)     buf_rd_d = buf_rd_q + PW'(1);
      out_d     = out_q + CW'(accept) - CW'(deliver);
      buf_cnt_d = buf_cnt_q + CW'(push) - CW'(pop);
      if (!STALL) begin
        if (!buf_empty) begin
          inst_pc_d   = buf_pc_q[buf_rd_q];
          inst_data_d = buf_data_q[buf_rd_q];
        end else if (deliver) begin
          inst_pc_d   = pcq_mem_q[pcq_rd_q];
          inst_data_d = INST_RDATA;
        end else begin
          inst_pc_d   = '0;
          inst_data_d = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      started_q   <= 1'b0;
      req_pc_q    <= RESET_PC & ~32'h3;
      out_q       <= '0;
      buf_cnt_q   <= '0;
      disc_q      <= '0;
      pcq_wr_q    <= '0;
      pcq_rd_q    <= '0;
      buf_wr_q    <= '0;
      buf_rd_q    <= '0;
      inst_pc_q   <= '0;
      inst_data_q <= '0;
    end else begin
      started_q   <= started_d;
      req_pc_q    <= req_pc_d;
      out_q       <= out_d;
      buf_cnt_q   <= buf_cnt_d;
      disc_q      <= disc_d;
      pcq_wr_q    <= pcq_wr_d;
      pcq_rd_q    <= pcq_rd_d;
      buf_wr_q    <= buf_wr_d;
      buf_rd_q    <= buf_rd_d;
      inst_pc_q   <= inst_pc_d;
      inst_data_q <= inst_data_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the counters above.
  always_ff @(posedge CLK) begin
    if (accept) pcq_mem_q[pcq_wr_q] <= req_pc_q;
    if (push) begin
      buf_pc_q[buf_wr_q]   <= pcq_mem_q[pcq_rd_q];
      buf_data_q[buf_wr_q] <= INST_RDATA;
    end
  end

  assign INST_PC   = inst_pc_q;
  assign INST_DATA = inst_data_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with programmable latency,
// immediate-assertion checks against hand-derived cycle-by-cycle expectations.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        RST;
  logic        FLUSH;
  logic [31:0] FLUSH_PC;
  logic        STALL;
  logic        INST_RDEN;
  logic [31:0] INST_RIADDR;
  logic        INST_RREADY;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic [31:0] INST_PC;
  logic [31:0] INST_DATA;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;
  int acc_cnt  = 0;
  int acc0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC), .STALL(STALL),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_RREADY(INST_RREADY),
    .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
    .INST_PC(INST_PC), .INST_DATA(INST_DATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record acceptance just before the edge, then drive the response due this cycle.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    @(negedge CLK);
    acc = INST_RDEN && INST_RREADY;
    a   = INST_RIADDR;
    @(posedge CLK);
    cyc++;
    if (acc) begin
      pend_addr.push_back(a);
      pend_due.push_back(cyc + lat - 1);
      acc_cnt++;
    end
    #1;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      INST_RVALID = 1'b1;
      INST_RDATA  = ~pend_addr.pop_front();
      void'(pend_due.pop_front());
    end else begin
      INST_RVALID = 1'b0;
      INST_RDATA  = '0;
    end
  endtask

  task automatic do_reset();
    RST = 1'b0; FLUSH = 1'b0; STALL = 1'b0; FLUSH_PC = '0;
    INST_RREADY = 1'b1; INST_RVALID = 1'b0; INST_RDATA = '0;
    pend_addr.delete();
    pend_due.delete();
    #1;
    chk("rst_pc", INST_PC, 32'h0);
    chk("rst_data", INST_DATA, 32'h0);
    chk("rst_rden", 32'(INST_RDEN), 32'h0);
    RST = 1'b1;
    #1;
    chk("rel_rden", 32'(INST_RDEN), 32'h0);
    cyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; FLUSH = 1'b0; STALL = 1'b0; FLUSH_PC = '0;
    INST_RREADY = 1'b1; INST_RVALID = 1'b0; INST_RDATA = '0;
    @(posedge CLK); @(posedge CLK); #1;

    // Sequential fetch, latency 1
    do_reset();
    tick();
    chk("e1_rden", 32'(INST_RDEN), 32'h1);
    chk("e1_addr", INST_RIADDR, 32'h100);
    chk("e1_pc", INST_PC, 32'h0);
    tick();
    chk("e2_addr", INST_RIADDR, 32'h104);
    chk("e2_pc", INST_PC, 32'h0);
    tick(); chk("seq_pc0", INST_PC, 32'h100); chk("seq_d0", INST_DATA, 32'hFFFF_FEFF);
    tick(); chk("seq_pc1", INST_PC, 32'h104); chk("seq_d1", INST_DATA, 32'hFFFF_FEFB);
    tick(); chk("seq_pc2", INST_PC, 32'h108); chk("seq_d2", INST_DATA, 32'hFFFF_FEF7);

    // Stall for three edges with (0x108, I2) on the output
    STALL = 1'b1;
    acc0  = acc_cnt;
    tick(); chk("stl_pc_a", INST_PC, 32'h108);
    tick(); chk("stl_pc_b", INST_PC, 32'h108); chk("stl_rden", 32'(INST_RDEN), 32'h0);
    tick(); chk("stl_pc_c", INST_PC, 32'h108); chk("stl_d_c", INST_DATA, 32'hFFFF_FEF7);
    chk("stl_issued", 32'(acc_cnt - acc0), 32'h1);
    STALL = 1'b0;
    tick(); chk("stl_out0", INST_PC, 32'h10C); chk("stl_d0", INST_DATA, 32'hFFFF_FEF3);
    tick(); chk("stl_out1", INST_PC, 32'h110);
    tick(); chk("stl_out2", INST_PC, 32'h114); chk("stl_d2", INST_DATA, 32'hFFFF_FEEB);

    // Flush with two reads outstanding, latency 3
    lat = 3;
    do_reset();
    tick(); tick(); tick();
    chk("fl_full_rden", 32'(INST_RDEN), 32'h0);
    FLUSH = 1'b1; FLUSH_PC = 32'h0000_2000;
    tick(); chk("fl_pc", INST_PC, 32'h0);
    FLUSH = 1'b0;
    #1;
    chk("fl_rden", 32'(INST_RDEN), 32'h1);
    chk("fl_addr", INST_RIADDR, 32'h2000);
    tick(); chk("fl_bub5", INST_PC, 32'h0);
    tick(); chk("fl_bub6", INST_PC, 32'h0); chk("fl_bubd6", INST_DATA, 32'h0);
    tick(); chk("fl_bub7", INST_PC, 32'h0);
    tick(); chk("fl_new_pc", INST_PC, 32'h2000); chk("fl_new_d", INST_DATA, 32'hFFFF_DFFF);
    tick(); chk("fl_nxt_pc", INST_PC, 32'h2004);

    // Flush and stall together; unaligned flush pc gets aligned
    STALL = 1'b1; FLUSH = 1'b1; FLUSH_PC = 32'h0000_3002;
    tick(); chk("fs_pc", INST_PC, 32'h0); chk("fs_data", INST_DATA, 32'h0);
    FLUSH = 1'b0; STALL = 1'b0;
    #1;
    chk("fs_addr", INST_RIADDR, 32'h3000);
    chk("fs_rden", 32'(INST_RDEN), 32'h1);
    tick(); chk("fs_bub11", INST_PC, 32'h0);
    tick(); chk("fs_bub12", INST_PC, 32'h0);
    tick(); chk("fs_bub13", INST_PC, 32'h0);
    tick(); chk("fs_new_pc", INST_PC, 32'h3000); chk("fs_new_d", INST_DATA, 32'hFFFF_CFFF);

    // Memory not ready for four cycles, latency 1
    lat = 1;
    do_reset();
    tick(); tick(); tick();
    chk("rr_pc3", INST_PC, 32'h100);
    INST_RREADY = 1'b0;
    tick();
    chk("rr_pc4", INST_PC, 32'h104);
    chk("rr_rden4", 32'(INST_RDEN), 32'h1);
    chk("rr_addr4", INST_RIADDR, 32'h108);
    for (int k = 5; k <= 7; k++) begin
      tick();
      chk("rr_bub", INST_PC, 32'h0);
      chk("rr_rden", 32'(INST_RDEN), 32'h1);
      chk("rr_addr", INST_RIADDR, 32'h108);
    end
    INST_RREADY = 1'b1;
    tick(); chk("rr_pc8", INST_PC, 32'h0);
    tick(); chk("rr_pc9", INST_PC, 32'h108);
    tick(); chk("rr_pc10", INST_PC, 32'h10C);

    // Address wrap at the top of the address space
    FLUSH = 1'b1; FLUSH_PC = 32'hFFFF_FFF8;
    tick(); chk("wr_flpc", INST_PC, 32'h0);
    FLUSH = 1'b0;
    #1;
    chk("wr_addr0", INST_RIADDR, 32'hFFFF_FFF8);
    tick(); chk("wr_addr1", INST_RIADDR, 32'hFFFF_FFFC);
    tick(); chk("wr_addr2", INST_RIADDR, 32'h0);
    chk("wr_pc0", INST_PC, 32'hFFFF_FFF8); chk("wr_d0", INST_DATA, 32'h7);
    tick(); chk("wr_pc1", INST_PC, 32'hFFFF_FFFC); chk("wr_d1", INST_DATA, 32'h3);
    tick(); chk("wr_pc2", INST_PC, 32'h0); chk("wr_d2", INST_DATA, 32'hFFFF_FFFF);
    tick(); chk("wr_pc3", INST_PC, 32'h4);

    // Asynchronous reset mid-stream, no clock edge in between
    RST = 1'b0;
    #1;
    chk("ar_pc", INST_PC, 32'h0);
    chk("ar_data", INST_DATA, 32'h0);
    chk("ar_rden", 32'(INST_RDEN), 32'h0);
    chk("ar_addr", INST_RIADDR, 32'h100);
    do_reset();
    tick(); chk("ar_e1_addr", INST_RIADDR, 32'h100); chk("ar_e1_rden", 32'(INST_RDEN), 32'h1);
    tick(); tick();
    chk("ar_pc0", INST_PC, 32'h100); chk("ar_d0", INST_DATA, 32'hFFFF_FEFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end fetch stage: generates sequential PCs, issues in-order instruction reads to instruction memory, and buffers returned words.
- Presents one registered {PC, instruction} pair per cycle to the first decode stage.
- Honours pipeline STALL (hold) and FLUSH (redirect to FLUSH_PC, squash in-flight reads).
- Bubbles are presented as PC=0, instruction=0.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, max (outstanding reads + buffered words); buffer entries = DEPTH; power of two, ≥2

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous active-low reset
FLUSH  input  1  redirect; squash all in-flight and buffered instructions
FLUSH_PC  input  32  new fetch address, sampled when FLUSH=1
STALL  input  1  downstream hold; INST_PC/INST_DATA must not change
INST_RDEN  output  1  read request valid
INST_RIADDR  output  32  read address (word aligned)
INST_RREADY  input  1  memory accepts request when INST_RDEN && INST_RREADY
INST_RVALID  input  1  read data valid; responses in request order, latency ≥1 cycle
INST_RDATA  input  32  returned instruction word
INST_PC  output  32  registered PC to decode
INST_DATA  output  32  registered instruction to decode

Behaviour:
- Reset (RST=0, async): req_pc=RESET_PC, outstanding=0, buffer empty, discard=0, INST_PC=0, INST_DATA=0. INST_RDEN is 0 while in reset and in the first cycle after release.
- Issue: INST_RDEN=1 iff !FLUSH && (outstanding + buf_count) < DEPTH. INST_RIADDR=req_pc (combinational).
- Acceptance: on acceptance, req_pc += 4 (32-bit wrap, 0xFFFF_FFFC→0) and outstanding += 1. The pc of the accepted request is pushed to a DEPTH-entry pc queue, which is popped on each non-discarded response.
- Response: INST_RVALID with discard>0 drops the word and decrements discard. Otherwise the pair {queued pc, INST_RDATA} is delivered and outstanding -= 1.
- Output register, when !STALL && !FLUSH, loads in priority order:
  - buffer head (pop), if buffer non-empty;
  - the delivered response (bypass), if buffer empty and a response is delivered this cycle;
  - {0,0} bubble, otherwise.
- Buffer write: when STALL=1, or the buffer is non-empty, a delivered response is written to the buffer tail.
- Buffer cannot overflow: the issue rule bounds outstanding + buf_count ≤ DEPTH.
- Latency: response at cycle t with empty buffer and no stall → visible on INST_PC/INST_DATA from t+1.
- STALL=1: output register holds. Issue continues under the DEPTH rule; responses fill the buffer.
- FLUSH=1 (overrides STALL):
  - req_pc=FLUSH_PC; buffer and pc queue cleared; INST_PC/INST_DATA=0; no issue that cycle.
  - discard = outstanding + discard − (1 if INST_RVALID this cycle).
  - outstanding=0.
  - First request at FLUSH_PC is issued the cycle after FLUSH deasserts.
- Back-to-back FLUSH: the last FLUSH_PC wins; discard accumulates correctly.
- INST_RVALID with outstanding=0 and discard=0 is a protocol violation; the response is ignored.
- FLUSH_PC[1:0] and RESET_PC[1:0] are forced to 0.

Test Plan:
- Reset release, RESET_PC=0x100, memory latency 1, always ready → RIADDR 0x100,0x104,0x108…; decode sees (0x100,I0),(0x104,I1)… every cycle after the initial two-cycle bubble.
- STALL held 3 cycles mid-stream at output (0x108,I2) → output holds 0x108; at most DEPTH=2 reads issued; after release, 0x10C then 0x110 delivered with no loss or duplication.
- FLUSH with FLUSH_PC=0x2000 while 2 reads outstanding (latency 3) → the two late responses are dropped; next visible pair is (0x2000,data@0x2000); output is 0/0 in between.
- FLUSH and STALL asserted together → output goes 0/0 in the next cycle; fetch restarts at FLUSH_PC.
- INST_RREADY low for 4 cycles → RDEN stays 1 with RIADDR stable; bubbles (0,0) output; no PC skipped.
- req_pc=0xFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; RST pulse mid-stream (async, no clock) → all outputs 0 immediately; fetch restarts at RESET_PC.
